// File: rtl/dmem_pkg.sv
// dmem_pkg: shared definitions for the data memory with clear sweep.
//   - state_e   : clear sequencer states (CLEAR, IDLE)
//   - ptr_width : width of the sweep pointer for a given depth (clog2, min 1)
//   - DEF_*     : default geometry of the memory
package dmem_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DEPTH  = 256;

  typedef enum logic {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } state_e;

  // A one-word memory still needs a 1-bit pointer, so clamp at 1.
  function automatic int ptr_width(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/dmem_clear_ctrl.sv
// dmem_clear_ctrl: clear sequencer for data_mem_sweep.
// Walks a pointer from 0 to DEPTH-1, requesting a zero write per cycle,
// after reset or when clr is seen in IDLE.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   clr          : start a sweep (only honoured in IDLE)
//   busy         : high while sweeping (registered)
//   sweep_we     : write a zero to sweep_addr this cycle
//   sweep_addr   : word currently being cleared
//   state_o      : current FSM state (debug visibility)
module dmem_clear_ctrl
  import dmem_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  localparam int PTR_W = ptr_width(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  output logic             busy,
  output logic             sweep_we,
  output logic [PTR_W-1:0] sweep_addr,
  output logic             state_o
);

  localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

  state_e           state_q, state_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic             busy_q, busy_d;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= CLEAR;
      ptr_q   <= '0;
      busy_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      busy_q  <= busy_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    busy_d  = busy_q;
    case (state_q)
      CLEAR: begin
        if (ptr_q == LAST) begin
          state_d = IDLE;
          ptr_d   = '0;
          busy_d  = 1'b0;
        end else begin
          ptr_d = ptr_q + 1'b1;
        end
      end
      IDLE: begin
        // First zero write happens on the cycle after clr is taken.
        if (clr) begin
          state_d = CLEAR;
          ptr_d   = '0;
          busy_d  = 1'b1;
        end
      end
      default: begin
        state_d = CLEAR;
        ptr_d   = '0;
        busy_d  = 1'b1;
      end
    endcase
  end

  // Outputs; no sweep writes while reset is held so memory is untouched.
  always_comb begin
    sweep_we   = (state_q == CLEAR) && !rst;
    sweep_addr = ptr_q;
    busy       = busy_q;
    state_o    = state_q;
  end

endmodule

// File: rtl/data_mem_sweep.sv
// data_mem_sweep: single-port data memory with registered read, read-valid
// strobe and a multi-cycle hardware clear sweep (storage has no reset so it
// can map to block RAM).
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   clr       : request a full clear sweep (sampled only when not busy)
//   we, re    : write / read enable
//   A, WD     : word address, write data
//   RD        : registered read data (1-cycle latency, holds when idle)
//   rd_valid  : one-cycle strobe, RD valid this cycle
//   busy      : clear sweep running; user accesses are ignored
// Handshake: an access is accepted on any edge where busy=0 and clr=0;
// a read accepted at edge N shows RD/rd_valid after edge N.
module data_mem_sweep
  import dmem_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DEPTH  = DEF_DEPTH,
  localparam int PTR_W = ptr_width(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] A,
  input  logic [DATA_W-1:0] WD,
  output logic [DATA_W-1:0] RD,
  output logic              rd_valid,
  output logic              busy
);

  logic [DATA_W-1:0] mem [DEPTH];

  logic             sweep_we;
  logic [PTR_W-1:0] sweep_addr;
  logic             ctrl_state;

  logic              in_range, accept, user_we, mem_we;
  logic [PTR_W-1:0]  a_idx, mem_addr;
  logic [DATA_W-1:0] mem_wd;
  logic [DATA_W-1:0] rd_q, rd_d;
  logic              rd_valid_q, rd_valid_d;

  dmem_clear_ctrl #(.DEPTH(DEPTH)) u_clear_ctrl (
    .clk        (clk),
    .rst        (rst),
    .clr        (clr),
    .busy       (busy),
    .sweep_we   (sweep_we),
    .sweep_addr (sweep_addr),
    .state_o    (ctrl_state)
  );

  always_comb begin
    // Unsigned 32-bit compare so DEPTH == 2**ADDR_W does not truncate.
    in_range = 32'(A) < 32'(DEPTH);
    a_idx    = A[PTR_W-1:0];
    // clr has priority over a same-cycle access.
    accept   = !busy && !clr;
    user_we  = accept && we && in_range && !rst;
    mem_we   = sweep_we || user_we;
    mem_addr = sweep_we ? sweep_addr : a_idx;
    mem_wd   = sweep_we ? '0 : WD;

    rd_valid_d = accept && re;
    rd_d       = rd_q;
    if (rd_valid_d) begin
      if (!in_range)  rd_d = '0;
      else if (we)    rd_d = WD;          // write-first bypass
      else            rd_d = mem[a_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wd;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_q       <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_q       <= rd_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign RD       = rd_q;
  assign rd_valid = rd_valid_q;

endmodule

// File: tb/tb_data_mem_sweep.sv
// tb_data_mem_sweep: drives two instances (DEPTH=16/ADDR_W=8 and
// DEPTH=12/ADDR_W=4) from shared stimulus and checks both against a
// behavioural model every cycle, plus literal expectations.
module tb_data_mem_sweep;

  logic       clk = 1'b0;
  logic       rst, clr, we, re;
  logic [7:0] A, WD;

  logic [7:0] rd16, rd12;
  logic       vld16, vld12, busy16, busy12;

  int total = 0;
  int bad   = 0;

  logic [7:0] exp_q[$];

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- DUTs ----------------
  data_mem_sweep #(.DATA_W(8), .ADDR_W(8), .DEPTH(16)) u_dut16 (
    .clk(clk), .rst(rst), .clr(clr), .we(we), .re(re),
    .A(A), .WD(WD), .RD(rd16), .rd_valid(vld16), .busy(busy16)
  );

  data_mem_sweep #(.DATA_W(8), .ADDR_W(4), .DEPTH(12)) u_dut12 (
    .clk(clk), .rst(rst), .clr(clr), .we(we), .re(re),
    .A(A[3:0]), .WD(WD), .RD(rd12), .rd_valid(vld12), .busy(busy12)
  );

  // ---------------- check helper ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // m_left = sweep cycles still to run (0 = idle); word cleared next is
  // depth - m_left.
  logic [7:0] m_mem [2][256];
  int         m_left [2];
  logic [7:0] m_rd [2];
  logic       m_vld [2];
  logic       m_init = 1'b0;

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      int dep, addr;
      dep  = (k == 0) ? 16 : 12;
      addr = (k == 0) ? int'(A) : int'(A[3:0]);
      if (rst) begin
        m_left[k] = dep;
        m_rd[k]   = 8'h00;
        m_vld[k]  = 1'b0;
        m_init    = 1'b1;
      end else if (m_left[k] > 0) begin
        m_mem[k][dep - m_left[k]] = 8'h00;
        m_left[k] = m_left[k] - 1;
        m_vld[k]  = 1'b0;
      end else if (clr) begin
        m_left[k] = dep;
        m_vld[k]  = 1'b0;
      end else begin
        m_vld[k] = re;
        if (re) begin
          if (addr >= dep) m_rd[k] = 8'h00;
          else if (we)     m_rd[k] = WD;
          else             m_rd[k] = m_mem[k][addr];
          if (k == 0) exp_q.push_back(m_rd[k]);
        end
        if (we && addr < dep) m_mem[k][addr] = WD;
      end
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (m_init) begin
      check("busy16",  32'(busy16), 32'(m_left[0] > 0));
      check("valid16", 32'(vld16),  32'(m_vld[0]));
      check("rd16",    32'(rd16),   32'(m_rd[0]));
      check("busy12",  32'(busy12), 32'(m_left[1] > 0));
      check("valid12", 32'(vld12),  32'(m_vld[1]));
      check("rd12",    32'(rd12),   32'(m_rd[1]));
      if (vld16 === 1'b1) begin
        if (exp_q.size() == 0) check("rdq16_empty", 32'(1), 32'(0));
        else                   check("rdq16", 32'(rd16), 32'(exp_q.pop_front()));
      end
    end
  end

  // ---------------- driver ----------------
  task automatic cyc(input logic r, input logic c, input logic w, input logic rr,
                     input logic [7:0] a, input logic [7:0] d);
    rst = r; clr = c; we = w; re = rr; A = a; WD = d;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
  endtask

  // Run until busy16 falls; returns number of busy cycles observed.
  task automatic wait_sweep(input string name, output int n);
    n = 0;
    while (busy16 === 1'b1 && n < 100) begin
      check({name, "_vld"}, 32'(vld16), 32'(0));
      idle();
      n++;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    rst = 1'b1; clr = 1'b0; we = 1'b0; re = 1'b0; A = 8'h00; WD = 8'h00;

    // 1. reset then sweep
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    check("reset_busy", 32'(busy16), 32'(1));
    check("reset_rd",   32'(rd16),   32'(0));
    check("reset_vld",  32'(vld16),  32'(0));
    n = 0;
    while (busy16 === 1'b1 && n < 100) begin
      check("sweep_rd", 32'(rd16), 32'(0));
      check("sweep_vld", 32'(vld16), 32'(0));
      idle();
      n++;
    end
    check("sweep_len", 32'(n), 32'(16));
    for (int i = 0; i < 16; i++) begin
      cyc(1'b0, 1'b0, 1'b0, 1'b1, 8'(i), 8'h00);
      check("post_sweep_rd",  32'(rd16), 32'(0));
      check("post_sweep_vld", 32'(vld16), 32'(1));
    end

    // 2. write/read latency
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 8'd5, 8'hA5);
    check("wr_no_vld", 32'(vld16), 32'(0));
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 8'd5, 8'h00);
    check("lat_rd",  32'(rd16), 32'hA5);
    check("lat_vld", 32'(vld16), 32'(1));
    idle();
    check("lat_vld_drop", 32'(vld16), 32'(0));
    check("lat_rd_hold",  32'(rd16), 32'hA5);

    // 3. simultaneous write + read
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 8'd7, 8'h3C);
    check("bypass_rd", 32'(rd16), 32'h3C);
    idle();
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 8'd7, 8'h00);
    check("bypass_mem", 32'(rd16), 32'h3C);

    // 4. software clear with ignored accesses
    for (int i = 0; i < 16; i++) cyc(1'b0, 1'b0, 1'b1, 1'b0, 8'(i), 8'hFF);
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 8'd4, 8'h77);   // same-cycle access dropped
    check("clr_busy", 32'(busy16), 32'(1));
    check("clr_vld",  32'(vld16), 32'(0));
    n = 0;
    while (busy16 === 1'b1 && n < 100) begin
      check("clr_sweep_vld", 32'(vld16), 32'(0));
      if (n == 0) cyc(1'b0, 1'b0, 1'b1, 1'b0, 8'd2, 8'h11);
      else        cyc(1'b0, 1'b0, 1'b0, 1'b1, 8'd3, 8'h00);
      n++;
    end
    check("clr_len", 32'(n), 32'(16));
    check("clr_end_vld", 32'(vld16), 32'(0));
    for (int i = 0; i < 16; i++) begin
      cyc(1'b0, 1'b0, 1'b0, 1'b1, 8'(i), 8'h00);
      check("clr_rd", 32'(rd16), 32'(0));
    end

    // 5. reset mid-sweep at ptr=9
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 8'd12, 8'h5A);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
    for (int i = 0; i < 9; i++) idle();
    check("mid_busy_pre", 32'(busy16), 32'(1));
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    check("mid_busy_rst", 32'(busy16), 32'(1));
    wait_sweep("mid", n);
    check("mid_len", 32'(n), 32'(16));
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 8'd12, 8'h00);
    check("mid_cleared", 32'(rd16), 32'(0));

    // 6. out of range on the DEPTH=12 instance
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 8'd1, 8'h42);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 8'd13, 8'h55);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 8'd13, 8'h00);
    check("oor_rd",  32'(rd12), 32'(0));
    check("oor_vld", 32'(vld12), 32'(1));
    check("in16_rd", 32'(rd16), 32'h55);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 8'd1, 8'h00);
    check("oor_a1",  32'(rd12), 32'h42);
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 8'd14, 8'h99);  // out-of-range write-first read
    check("oor_bypass", 32'(rd12), 32'(0));
    idle();
    idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
